fp_div_seq: RTL and testbench
=============================

// Module: fp_div_seq
// PURPOSE
//  Sequential floating-point divider; the subtract/divide counterpart of the add/align datapath.
//  Computes q = a / b by restoring division, one quotient bit per cycle. Exponent is
//  subtracted once. Result normalised and truncated. Sits beside the adder in the arithmetic unit.
//  Valid/ready on both operand and result sides.
// PARAMETERS
//  EXP_W   7   exponent width, two's complement; min code (-2^(EXP_W-1)) = zero, max code = infinity
//  FRAC_W  15  stored fraction width; significand = 1.f (hidden 1), FRAC_W+1 bits
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  async active-low reset
//  in_valid   in   1                  operands a,b valid
//  in_ready   out  1                  block idle, operands accepted when in_valid&in_ready
//  a          in   1+EXP_W+FRAC_W     dividend {sign, exp, frac}
//  b          in   1+EXP_W+FRAC_W     divisor  {sign, exp, frac}
//  out_valid  out  1                  result valid, held until out_ready
//  out_ready  in   1                  consumer takes result
//  q          out  1+EXP_W+FRAC_W     quotient {sign, exp, frac}
//  flags      out  4                  {inv, dz, ovf, unf}, valid with out_valid
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. in_ready=1 (combinational, IDLE only). out_valid=0, q=0, flags=0.
//  - FSM: IDLE -accept-> SETUP -> ITER (FRAC_W+2 cycles) -> NORM -> DONE; SETUP -special-> DONE;
//    DONE & out_ready -> IDLE (no accept in that same cycle).
//  - Latency at defaults: accept edge E0; out_valid rises at E19 (normal) or E1 (special).
//  - In DONE, q/flags stay stable while out_ready=0.
//  - Sign: q.sign = a.sign ^ b.sign, including zero/inf results. inv result sign = 0.
//  - Specials, decoded in SETUP, by priority:
//    1. (a zero & b zero) | (a inf & b inf) -> inv=1, q={0,max,all-ones frac}.
//    2. a inf -> inf.
//    3. b zero -> inf, dz=1.
//    4. a zero | b inf -> zero.
//    Inf = {s,max,0}. Zero = {s,min,0}.
//  - Exponent: e = sext(ea) - sext(eb), computed at EXP_W+1 bits in SETUP.
//  - Significands: A = {1,fa}, B = {1,fb}.
//  - Remainder R (FRAC_W+2 bits) = A. For i = FRAC_W+1 down to 0: if R >= B then R -= B, Q[i] = 1. Then R <<= 1.
//  - NORM:
//    - Q[FRAC_W+1] = 1 -> frac = Q[FRAC_W:1].
//    - Otherwise frac = Q[FRAC_W-1:0] and e -= 1.
//    - Truncation only, no rounding.
//  - Range check after NORM:
//    - e > max-1 -> inf, ovf=1.
//    - e < min+1 -> zero, unf=1.
//    - Otherwise q.exp = e[EXP_W-1:0].
//  - flags bits not listed above are 0. in_valid while busy is ignored. in_ready=0 outside IDLE.
// TESTING (defaults; hex = {s,exp,frac} fields)
//  - 6.0/3.0: a={0,02,4000}, b={0,01,4000} -> q={0,01,0000}, flags=0, out_valid at E19.
//  - 1.0/3.0: a={0,00,0000}, b={0,01,4000} -> Q=0xAAAA, q={0,7E,2AAA} (e=-2), flags=0.
//  - -6.0/3.0 -> q={1,01,0000}.
//  - x/0: a={0,05,1234}, b={1,40,0000} -> q={1,3F,0000}, dz=1, out_valid at E1.
//  - 0/0 -> q={0,3F,7FFF}, inv=1.
//  - Range:
//    - a={0,3E,0000} / b={0,42,0000} (e=124) -> inf, ovf=1.
//    - a={0,41,0000} / b={0,3E,0000} -> zero, unf=1.
//  - Backpressure/reset:
//    - Hold out_ready=0 for 5 cycles -> q, flags, out_valid stable and in_ready=0.
//    - Assert rst_n=0 mid-ITER -> next cycle IDLE, out_valid=0.
//    - New op afterwards completes correctly.

Source files
------------

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq : sequential floating-point divider (q = a / b)
//
// Restoring division, one quotient bit per clock. The exponent difference
// is formed once when the operands are set up. The result is normalised and
// truncated, with no rounding. Operands and result both use valid/ready
// handshakes.
//
// Number format {sign, exp, frac}:
//   exp is two's complement. Its minimum code means zero and its maximum
//   code means infinity. The significand is 1.frac.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block idle; operands taken on in_valid & in_ready
//   a, b       dividend / divisor {sign, exp, frac}
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes the result
//   q          quotient {sign, exp, frac}
//   flags      {inv, dz, ovf, unf}, qualified by out_valid
// ---------------------------------------------------------------------------
module fp_div_seq #(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     a,
  input  logic [EXP_W+FRAC_W:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     q,
  output logic [3:0]                flags
);

  localparam int CNT_W = $clog2(FRAC_W + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [EXP_W-1:0]    EXP_MAX  = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0]    EXP_MIN  = {1'b1, {(EXP_W-1){1'b0}}};
  // Legal result exponent range is [min+1, max-1], expressed at EXP_W+1 bits.
  localparam logic [EXP_W:0]      E_HI     = {2'b00, {(EXP_W-2){1'b1}}, 1'b0};
  localparam logic [EXP_W:0]      E_LO     = {2'b11, {(EXP_W-2){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(FRAC_W + 1);
  localparam logic [FRAC_W-1:0]   FRAC_0   = {FRAC_W{1'b0}};
  localparam logic [FRAC_W-1:0]   FRAC_1   = {FRAC_W{1'b1}};

  logic [2:0]              state_q,     state_d;
  logic [EXP_W+FRAC_W:0]   a_q,         a_d;
  logic [EXP_W+FRAC_W:0]   b_q,         b_d;
  logic [EXP_W:0]          exp_q,       exp_d;
  logic [FRAC_W+1:0]       rem_q,       rem_d;
  logic [FRAC_W+1:0]       quo_q,       quo_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [EXP_W+FRAC_W:0]   q_q,         q_d;
  logic [3:0]              flags_q,     flags_d;
  logic                    out_valid_q, out_valid_d;

  // Operand field decode (from the latched operands)
  logic                    sign_s;
  logic [EXP_W-1:0]        ea_s, eb_s;
  logic [FRAC_W:0]         sig_a_s, sig_b_s;
  logic                    a_zero_s, b_zero_s, a_inf_s, b_inf_s;
  logic [FRAC_W+1:0]       rem_sub_s, rem_sel_s;
  logic                    ge_s;
  logic [EXP_W:0]          exp_n_s;
  logic [FRAC_W-1:0]       frac_n_s;

  assign sign_s   = a_q[EXP_W+FRAC_W] ^ b_q[EXP_W+FRAC_W];
  assign ea_s     = a_q[EXP_W+FRAC_W-1:FRAC_W];
  assign eb_s     = b_q[EXP_W+FRAC_W-1:FRAC_W];
  assign sig_a_s  = {1'b1, a_q[FRAC_W-1:0]};
  assign sig_b_s  = {1'b1, b_q[FRAC_W-1:0]};
  assign a_zero_s = (ea_s == EXP_MIN);
  assign b_zero_s = (eb_s == EXP_MIN);
  assign a_inf_s  = (ea_s == EXP_MAX);
  assign b_inf_s  = (eb_s == EXP_MAX);

  // One restoring step: subtract the divisor when it fits.
  assign ge_s      = (rem_q >= {1'b0, sig_b_s});
  assign rem_sub_s = rem_q - {1'b0, sig_b_s};
  assign rem_sel_s = ge_s ? rem_sub_s : rem_q;

  // Normalise: quotient lies in (0.5, 2); pick the field under the leading one.
  always_comb begin
    if (quo_q[FRAC_W+1]) begin
      frac_n_s = quo_q[FRAC_W:1];
      exp_n_s  = exp_q;
    end else begin
      frac_n_s = quo_q[FRAC_W-1:0];
      exp_n_s  = exp_q - {{EXP_W{1'b0}}, 1'b1};
    end
  end

  // Next-state and datapath control for the divider FSM
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
          q_d         = {1'b0, EXP_MAX, FRAC_1};
          flags_d     = 4'b1000;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (a_inf_s) begin
          q_d         = {sign_s, EXP_MAX, FRAC_0};
          flags_d     = 4'b0000;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (b_zero_s) begin
          q_d         = {sign_s, EXP_MAX, FRAC_0};
          flags_d     = 4'b0100;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (a_zero_s || b_inf_s) begin
          q_d         = {sign_s, EXP_MIN, FRAC_0};
          flags_d     = 4'b0000;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          exp_d   = {ea_s[EXP_W-1], ea_s} - {eb_s[EXP_W-1], eb_s};
          rem_d   = {1'b0, sig_a_s};
          quo_d   = {(FRAC_W+2){1'b0}};
          cnt_d   = CNT_INIT;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = {rem_sel_s[FRAC_W:0], 1'b0};
        quo_d = {quo_q[FRAC_W:0], ge_s};
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_NORM;
        end else begin
          state_d = S_ITER;
        end
      end
      S_NORM: begin
        if ($signed(exp_n_s) > $signed(E_HI)) begin
          q_d     = {sign_s, EXP_MAX, FRAC_0};
          flags_d = 4'b0010;
        end else if ($signed(exp_n_s) < $signed(E_LO)) begin
          q_d     = {sign_s, EXP_MIN, FRAC_0};
          flags_d = 4'b0001;
        end else begin
          q_d     = {sign_s, exp_n_s[EXP_W-1:0], frac_n_s};
          flags_d = 4'b0000;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      exp_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_div_seq : self-checking bench for fp_div_seq (defaults 7/15).
// Expected results come from an arithmetic model: class decode, then
// floor(A*2^16/B), normalisation and range clamp. Directed cases and
// random operands are pushed through a scoreboard queue. One compare
// process checks every result handshake.
// ---------------------------------------------------------------------------
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] a;
  logic [22:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] q;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;
  logic [26:0] sb[$];

  fp_div_seq #(.EXP_W(7), .FRAC_W(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic s, input logic [6:0] e, input logic [14:0] f);
    return {s, e, f};
  endfunction

  function automatic bit is_special(input logic [22:0] x, input logic [22:0] y);
    return (x[21:15] == 7'h40) || (x[21:15] == 7'h3F) ||
           (y[21:15] == 7'h40) || (y[21:15] == 7'h3F);
  endfunction

  // Reference: returns {q, flags}
  function automatic logic [26:0] model(input logic [22:0] x, input logic [22:0] y);
    logic        s;
    logic [6:0]  ex, ey, ev;
    bit          xz, yz, xi, yi;
    int          e;
    longint      num, den, quo;
    logic [14:0] fr;
    s  = x[22] ^ y[22];
    ex = x[21:15];
    ey = y[21:15];
    xz = (ex == 7'h40); yz = (ey == 7'h40);
    xi = (ex == 7'h3F); yi = (ey == 7'h3F);
    if ((xz && yz) || (xi && yi)) return {1'b0, 7'h3F, 15'h7FFF, 4'b1000};
    if (xi)                       return {s, 7'h3F, 15'h0000, 4'b0000};
    if (yz)                       return {s, 7'h3F, 15'h0000, 4'b0100};
    if (xz || yi)                 return {s, 7'h40, 15'h0000, 4'b0000};
    e   = int'($signed(ex)) - int'($signed(ey));
    num = longint'(32768 + int'(x[14:0])) * 65536;
    den = longint'(32768 + int'(y[14:0]));
    quo = num / den;
    if (quo >= 65536) begin
      fr = 15'((quo / 2) % 32768);
    end else begin
      fr = 15'(quo % 32768);
      e  = e - 1;
    end
    if (e > 62)  return {s, 7'h3F, 15'h0000, 4'b0010};
    if (e < -63) return {s, 7'h40, 15'h0000, 4'b0001};
    ev = 7'(e);
    return {s, ev, fr, 4'b0000};
  endfunction

  // Single compare process: every result handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        chk("q",     {9'd0, q},      {9'd0, sb[0][26:4]});
        chk("flags", {28'd0, flags}, {28'd0, sb[0][3:0]});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        void'(sb.pop_front());
      end
    end
  end

  // Run one operation; exp_lat < 0 skips the latency check
  task automatic do_op(input logic [22:0] x, input logic [22:0] y, input int exp_lat, input int hold);
    int          lat;
    logic [22:0] q_h;
    logic [3:0]  f_h;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    // Garbage on the operand side while busy must be ignored
    in_valid = 1'($urandom);
    a = 23'($urandom);
    b = 23'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'($urandom);
    end
    if (!out_valid) begin
      chk("timeout", 32'd1, 32'd0);
      sb.delete();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      if (exp_lat >= 0) chk("latency", lat, exp_lat);
      q_h = q;
      f_h = flags;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        in_valid = 1'($urandom);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_q",     {9'd0, q},          {9'd0, q_h});
        chk("hold_flags", {28'd0, flags},     {28'd0, f_h});
        chk("hold_ready", {31'd0, in_ready},  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("drop_valid", {31'd0, out_valid}, 32'd0);
      chk("back_idle",  {31'd0, in_ready},  32'd1);
    end
  endtask

  initial begin
    logic [22:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q",         {9'd0, q},          32'd0);
    chk("rst_flags",     {28'd0, flags},     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model to hand-computed values
    chk("pin_6_3",   model(mk(0,7'h02,15'h4000), mk(0,7'h01,15'h4000)), {1'b0,7'h01,15'h0000,4'b0000});
    chk("pin_1_3",   model(mk(0,7'h00,15'h0000), mk(0,7'h01,15'h4000)), {1'b0,7'h7E,15'h2AAA,4'b0000});
    chk("pin_m6_3",  model(mk(1,7'h02,15'h4000), mk(0,7'h01,15'h4000)), {1'b1,7'h01,15'h0000,4'b0000});
    chk("pin_dz",    model(mk(0,7'h05,15'h1234), mk(1,7'h40,15'h0000)), {1'b1,7'h3F,15'h0000,4'b0100});
    chk("pin_0_0",   model(mk(0,7'h40,15'h0000), mk(0,7'h40,15'h0000)), {1'b0,7'h3F,15'h7FFF,4'b1000});
    chk("pin_ovf",   model(mk(0,7'h3E,15'h0000), mk(0,7'h42,15'h0000)), {1'b0,7'h3F,15'h0000,4'b0010});
    chk("pin_unf",   model(mk(0,7'h41,15'h0000), mk(0,7'h3E,15'h0000)), {1'b0,7'h40,15'h0000,4'b0001});

    // Directed cases through the DUT
    do_op(mk(0,7'h02,15'h4000), mk(0,7'h01,15'h4000), 19, 0);
    do_op(mk(0,7'h00,15'h0000), mk(0,7'h01,15'h4000), 19, 5);
    do_op(mk(1,7'h02,15'h4000), mk(0,7'h01,15'h4000), 19, 1);
    do_op(mk(0,7'h05,15'h1234), mk(1,7'h40,15'h0000), 1, 5);
    do_op(mk(0,7'h40,15'h0000), mk(0,7'h40,15'h0000), 1, 0);
    do_op(mk(1,7'h3F,15'h0000), mk(0,7'h3F,15'h0000), 1, 0);
    do_op(mk(1,7'h3F,15'h0000), mk(1,7'h03,15'h0000), 1, 0);
    do_op(mk(0,7'h40,15'h0000), mk(1,7'h3F,15'h0000), 1, 0);
    do_op(mk(0,7'h3E,15'h0000), mk(0,7'h42,15'h0000), 19, 0);
    do_op(mk(0,7'h41,15'h0000), mk(0,7'h3E,15'h0000), 19, 2);

    // Reset in the middle of the iteration phase
    in_valid = 1'b1;
    a = mk(0,7'h10,15'h1111);
    b = mk(0,7'h02,15'h2222);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready},  32'd1);
    chk("midrst_q",     {9'd0, q},          32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(mk(0,7'h02,15'h4000), mk(0,7'h01,15'h4000), 19, 0);

    // Random operands, with special exponents injected often
    for (int n = 0; n < 150; n++) begin
      ra = 23'($urandom);
      rb = 23'($urandom);
      case ($urandom_range(0, 9))
        0: ra[21:15] = 7'h40;
        1: rb[21:15] = 7'h40;
        2: ra[21:15] = 7'h3F;
        3: rb[21:15] = 7'h3F;
        default: ;
      endcase
      do_op(ra, rb, is_special(ra, rb) ? 1 : 19, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
